// File: rtl/im_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Default word/address widths and the frame sync marker live here.
package im_pkg;

   localparam int         IM_INSTR_SIZE  = 32;
   localparam int         IM_PC_SIZE     = 8;
   localparam logic [7:0] SYNC_BYTE      = 8'hA5;
   localparam int         BYTES_PER_WORD = IM_INSTR_SIZE / 8;

   // A one-byte word still needs a one-bit counter to keep port widths legal.
   function automatic int bcnt_width(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

   localparam int BCNT_W = bcnt_width(BYTES_PER_WORD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } ld_state_e;

endpackage

// File: rtl/im_word_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
// word_out/word_full show the word that the current byte would complete.
module im_word_assembler
   import im_pkg::*;
#(
   parameter int W = IM_INSTR_SIZE
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [7:0]   byte_in,
   input  logic         byte_en,
   input  logic         clear,
   output logic [W-1:0] word_out,
   output logic         word_full
);

   localparam int            BPW  = W / 8;
   localparam int            CW   = bcnt_width(BPW);
   localparam logic [CW-1:0] LAST = CW'(BPW - 1);

   logic [W-1:0]  shift_q, shift_d;
   logic [CW-1:0] bcnt_q, bcnt_d;

   always_comb begin
      word_out  = (shift_q << 4'd8) | W'(byte_in);
      word_full = byte_en && !clear && (bcnt_q == LAST);
      shift_d   = shift_q;
      bcnt_d    = bcnt_q;
      if (clear) begin
         shift_d = '0;
         bcnt_d  = '0;
      end else if (byte_en) begin
         shift_d = word_out;
         bcnt_d  = word_full ? '0 : (bcnt_q + CW'(1));
      end else begin
         shift_d = shift_q;
         bcnt_d  = bcnt_q;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         shift_q <= '0;
         bcnt_q  <= '0;
      end else begin
         shift_q <= shift_d;
         bcnt_q  <= bcnt_d;
      end
   end

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses sync/length/data/checksum frames
// from a byte stream, writes assembled words to IM and holds the CPU meanwhile.
module im_loader
   import im_pkg::*;
#(
   parameter int INSTR_SIZE = IM_INSTR_SIZE,
   parameter int PC_SIZE    = IM_PC_SIZE
) (
   input  logic                  clk,
   input  logic                  n_reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   input  logic                  abort,
   output logic                  im_we,
   output logic [PC_SIZE-1:0]    im_waddr,
   output logic [INSTR_SIZE-1:0] im_wdata,
   output logic                  cpu_hold,
   output logic                  load_done,
   output logic                  load_err
);

   localparam logic [16:0] MAX_WORDS = 17'd1 << PC_SIZE;

   ld_state_e             state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [PC_SIZE-1:0]    addr_q, addr_d;
   logic [7:0]            csum_q, csum_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  im_we_q, im_we_d;
   logic [PC_SIZE-1:0]    im_waddr_q, im_waddr_d;
   logic [INSTR_SIZE-1:0] im_wdata_q, im_wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  load_done_q, load_done_d;
   logic                  load_err_q, load_err_d;

   logic                  accept_s, idle_like_s, abort_s, sync_s;
   logic                  asm_en_s, word_full_s;
   logic [INSTR_SIZE-1:0] word_s;
   logic [15:0]           len_s;

   assign accept_s    = rx_valid && rx_ready_q;
   assign idle_like_s = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
   assign abort_s     = abort && !idle_like_s;
   assign sync_s      = accept_s && idle_like_s && (rx_data == SYNC_BYTE);
   assign asm_en_s    = accept_s && !abort_s && (state_q == ST_DATA);
   assign len_s       = {cnt_q[15:8], rx_data};

   im_word_assembler #(.W(INSTR_SIZE)) u_asm (
      .clk       (clk),
      .n_reset   (n_reset),
      .byte_in   (rx_data),
      .byte_en   (asm_en_s),
      .clear     (sync_s),
      .word_out  (word_s),
      .word_full (word_full_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      csum_d      = csum_q;
      im_waddr_d  = im_waddr_q;
      im_wdata_d  = im_wdata_q;
      cpu_hold_d  = cpu_hold_q;
      load_done_d = load_done_q;
      load_err_d  = load_err_q;
      // Abort beats any byte arriving on the same edge, so a pending word is never written.
      if (abort_s) begin
         state_d    = ST_ERR;
         load_err_d = 1'b1;
         cpu_hold_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (sync_s) begin
                  state_d     = ST_LEN_HI;
                  cpu_hold_d  = 1'b1;
                  load_done_d = 1'b0;
                  load_err_d  = 1'b0;
                  addr_d      = '0;
                  csum_d      = 8'h00;
                  cnt_d       = 16'h0000;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LEN_HI: begin
               if (accept_s) begin
                  cnt_d   = {rx_data, 8'h00};
                  state_d = ST_LEN_LO;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LEN_LO: begin
               if (accept_s) begin
                  cnt_d = len_s;
                  if ({1'b0, len_s} > MAX_WORDS) begin
                     state_d    = ST_ERR;
                     load_err_d = 1'b1;
                  end else if (len_s == 16'h0000) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_DATA: begin
               if (asm_en_s) begin
                  csum_d = csum_q ^ rx_data;
                  if (word_full_s) begin
                     state_d    = ST_WRITE;
                     im_waddr_d = addr_q;
                     im_wdata_d = word_s;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            ST_WRITE: begin
               addr_d  = addr_q + PC_SIZE'(1);
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: begin
               if (accept_s) begin
                  if (rx_data == csum_q) begin
                     state_d     = ST_DONE;
                     load_done_d = 1'b1;
                     cpu_hold_d  = 1'b0;
                  end else begin
                     state_d    = ST_ERR;
                     load_err_d = 1'b1;
                  end
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      rx_ready_d = (state_d != ST_WRITE);
      im_we_d    = (state_d == ST_WRITE);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 16'h0000;
         addr_q      <= '0;
         csum_q      <= 8'h00;
         rx_ready_q  <= 1'b1;
         im_we_q     <= 1'b0;
         im_waddr_q  <= '0;
         im_wdata_q  <= '0;
         cpu_hold_q  <= 1'b0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         csum_q      <= csum_d;
         rx_ready_q  <= rx_ready_d;
         im_we_q     <= im_we_d;
         im_waddr_q  <= im_waddr_d;
         im_wdata_q  <= im_wdata_d;
         cpu_hold_q  <= cpu_hold_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign im_we     = im_we_q;
   assign im_waddr  = im_waddr_q;
   assign im_wdata  = im_wdata_q;
   assign cpu_hold  = cpu_hold_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;

endmodule
